// File: rtl/prog_run_ctrl.sv
// Run/halt sequencer for the 3BC program counter: clears the PC on Start, advances it
// every RUN cycle, holds it through stalls and stops on halt or watchdog timeout.
module prog_run_ctrl #(
    parameter int unsigned CYC_W     = 16,
    parameter int unsigned STALL_CYC = 2,
    parameter int unsigned MAX_CYC   = 60000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             HaltDec,
    input  logic             StallReq,
    input  logic             BranchDec,
    output logic             PcEn,
    output logic             PcClr,
    output logic             PcBranchEn,
    output logic             Busy,
    output logic             Done,
    output logic             TimeoutErr,
    output logic [CYC_W-1:0] CycleCnt,
    output logic [CYC_W-1:0] InstrCnt
);

    localparam int unsigned STALL_W = 4;
    localparam logic [CYC_W-1:0]   WD_LAST    = CYC_W'(MAX_CYC - 1);
    localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(STALL_CYC);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_STALL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [STALL_W-1:0] stall_cnt;
    logic               resume;

    logic wd_hit;
    logic start_acc;
    logic retire;
    logic run_adv;
    logic wd_exit;
    logic stall_load;
    logic resume_set;
    logic counting;

    assign wd_hit   = (CycleCnt == WD_LAST);
    assign counting = (state == S_RUN) || (state == S_STALL);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle event strobes; RUN rules are first-match priority
    always_comb begin
        state_nxt  = state;
        start_acc  = 1'b0;
        retire     = 1'b0;
        run_adv    = 1'b0;
        wd_exit    = 1'b0;
        stall_load = 1'b0;
        resume_set = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    start_acc = 1'b1;
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (HaltDec) begin
                    retire    = 1'b1;
                    state_nxt = S_DONE;
                end else if (wd_hit) begin
                    wd_exit   = 1'b1;
                    state_nxt = S_DONE;
                end else if (StallReq && !resume) begin
                    stall_load = 1'b1;
                    state_nxt  = S_STALL;
                end else begin
                    retire  = 1'b1;
                    run_adv = 1'b1;
                end
            end
            S_STALL: begin
                if (wd_hit) begin
                    wd_exit   = 1'b1;
                    state_nxt = S_DONE;
                end else if (stall_cnt == STALL_LAST) begin
                    resume_set = 1'b1;
                    state_nxt  = S_RUN;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs: PC enables are Mealy on the decode inputs, the rest decode registered state
    always_comb begin
        PcEn       = 1'b0;
        PcClr      = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            S_CLEAR: begin
                PcClr = 1'b1;
                Busy  = 1'b1;
            end
            S_RUN: begin
                Busy = 1'b1;
                PcEn = !HaltDec && !wd_hit && !(StallReq && !resume);
            end
            S_STALL: begin
                Busy = 1'b1;
            end
            S_DONE: begin
                Done = 1'b1;
            end
            default: begin
                PcEn = 1'b0;
            end
        endcase
        PcBranchEn = BranchDec & PcEn;
    end

    // Run counters and timeout flag; cleared when a new run is accepted
    always_ff @(posedge Clk) begin
        if (Reset) begin
            CycleCnt   <= '0;
            InstrCnt   <= '0;
            TimeoutErr <= 1'b0;
        end else if (start_acc) begin
            CycleCnt   <= '0;
            InstrCnt   <= '0;
            TimeoutErr <= 1'b0;
        end else begin
            if (counting && (CycleCnt != '1)) begin
                CycleCnt <= CycleCnt + CYC_W'(1);
            end
            if (retire && (InstrCnt != '1)) begin
                InstrCnt <= InstrCnt + CYC_W'(1);
            end
            if (wd_exit) begin
                TimeoutErr <= 1'b1;
            end
        end
    end

    // Stall hold counter and the one-cycle StallReq mask after a stall
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt <= '0;
            resume    <= 1'b0;
        end else begin
            if (stall_load) begin
                stall_cnt <= STALL_LOAD;
            end else if (state == S_STALL) begin
                stall_cnt <= stall_cnt - STALL_W'(1);
            end
            if (state == S_CLEAR || run_adv) begin
                resume <= 1'b0;
            end else if (resume_set) begin
                resume <= 1'b1;
            end
        end
    end

endmodule
